// File: rtl/md_unit_param_pkg.sv
// Shared definitions for the parametrised multiply/divide unit.
// Opcode encoding, FSM states and default latencies used by md_unit_param.
package md_unit_param_pkg;

  localparam int unsigned MD_OP_W           = 3;
  localparam int unsigned MD_MUL_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_OP_MULTU = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_DIVU  = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_MSUB  = 3'd4,
    MD_OP_MSUBU = 3'd5,
    MD_OP_MADD  = 3'd6,
    MD_OP_MADDU = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  function automatic logic md_op_is_div(md_op_e op);
    return (op == MD_OP_DIVU) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational WIDTH-bit divider, signed or unsigned.
// Divide by zero yields quotient all-ones and remainder = dividend.
module md_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Magnitude divide then re-sign; MIN/-1 wraps back to MIN with remainder 0.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
    q_mag = '0;
    r_mag = '0;
    quo   = '1;
    rem   = a;
    if (b != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      quo   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
      rem   = a_neg ? (~r_mag + 1'b1) : r_mag;
    end
  end

endmodule

// File: rtl/md_unit_param.sv
// Multiply/divide unit with HI/LO for the E stage: mult/div/madd/msub, mthi/mtlo,
// configurable latency per class, cancel, and a registered busy for hazard stalls.
module md_unit_param
  import md_unit_param_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic               cancel,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] pend;

  md_op_e             op;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               accept;

  assign op     = md_op_e'(md_op);
  assign acc    = {hi, lo};
  assign accept = start && !cancel && (state == ST_IDLE);

  md_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .a        (a),
    .b        (b),
    .is_signed(op == MD_OP_DIV),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    result = prod_u;
    case (op)
      MD_OP_MULTU: result = prod_u;
      MD_OP_MULT:  result = prod_s;
      MD_OP_DIVU,
      MD_OP_DIV:   result = {div_rem, div_quo};
      MD_OP_MSUB:  result = acc - prod_s;
      MD_OP_MSUBU: result = acc - prod_u;
      MD_OP_MADD:  result = acc + prod_s;
      MD_OP_MADDU: result = acc + prod_u;
      default:     result = prod_u;
    endcase
  end

  // Counter runs N-1 down to 0, so RUN (and busy) lasts exactly N cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      pend  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pend  <= result;
            cnt   <= md_op_is_div(op) ? DIV_LOAD : MUL_LOAD;
            state <= ST_RUN;
            busy  <= 1'b1;
          end else if (!start) begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= pend;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: two instances (5/10 and 1/33 cycle latencies)
// driven by directed and random ops, checked against a 64-bit arithmetic model.
module tb_md_unit_param;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic [1:0]       start_s;
  logic [1:0][2:0]  op_s;
  logic [1:0][31:0] a_s;
  logic [1:0][31:0] b_s;
  logic [1:0]       hiwe_s;
  logic [1:0]       lowe_s;
  logic [1:0]       cancel_s;
  logic [1:0]       busy_s;
  logic [1:0][31:0] hi_s;
  logic [1:0][31:0] lo_s;

  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon_e;
  int          mcnt [2];
  int          total;
  int          bad;

  md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .md_op(op_s[0]),
    .a(a_s[0]), .b(b_s[0]), .hi_we(hiwe_s[0]), .lo_we(lowe_s[0]),
    .cancel(cancel_s[0]), .busy(busy_s[0]), .hi(hi_s[0]), .lo(lo_s[0])
  );

  md_unit_param #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(33)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .md_op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]), .hi_we(hiwe_s[1]), .lo_we(lowe_s[1]),
    .cancel(cancel_s[1]), .busy(busy_s[1]), .hi(hi_s[1]), .lo(lo_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int ncyc(input int d, input logic [2:0] op);
    if (op == 3'd2 || op == 3'd3) return (d == 0) ? 10 : 33;
    return (d == 0) ? 5 : 1;
  endfunction

  // Reference: plain 64-bit arithmetic on the operands.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] pu;
    logic [63:0] ps;
    logic [63:0] acc;
    logic [63:0] tq;
    logic [63:0] tr;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    pu  = ua * ub;
    ps  = sa * sb;
    acc = {hi, lo};
    case (op)
      3'd0: return pu;
      3'd1: return ps;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        tq = ua / ub;
        tr = ua % ub;
        return {tr[31:0], tq[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        tq = sq;
        tr = sr;
        return {tr[31:0], tq[31:0]};
      end
      3'd4: return acc - ps;
      3'd5: return acc - pu;
      3'd6: return acc + ps;
      default: return acc + pu;
    endcase
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_s[d] && n < 200) begin
      tick();
      n++;
    end
    check("idle_within_bound", {63'd0, busy_s[d]}, 64'd0);
  endtask

  task automatic do_op(input int d, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit with_mt);
    logic [63:0] r;
    exp_t        e;
    r           = model(op, a, b, mhi[d], mlo[d]);
    start_s[d]  = 1'b1;
    op_s[d]     = op;
    a_s[d]      = a;
    b_s[d]      = b;
    hiwe_s[d]   = with_mt;
    lowe_s[d]   = with_mt;
    tick();
    start_s[d]  = 1'b0;
    hiwe_s[d]   = 1'b0;
    lowe_s[d]   = 1'b0;
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.len = ncyc(d, op);
    push(d, e);
    mhi[d] = r[63:32];
    mlo[d] = r[31:0];
    wait_idle(d);
  endtask

  task automatic do_mt(input int d, input bit hw, input bit lw, input logic [31:0] a);
    hiwe_s[d] = hw;
    lowe_s[d] = lw;
    a_s[d]    = a;
    tick();
    hiwe_s[d] = 1'b0;
    lowe_s[d] = 1'b0;
    if (hw) mhi[d] = a;
    if (lw) mlo[d] = a;
    check("mthi_mtlo", {hi_s[d], lo_s[d]}, {mhi[d], mlo[d]});
  endtask

  // Cancel k cycles after start (k >= 2); a start and mt writes are tried while busy.
  task automatic do_cancel(input int d, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int k);
    exp_t e;
    start_s[d] = 1'b1;
    op_s[d]    = op;
    a_s[d]     = a;
    b_s[d]     = b;
    tick();
    op_s[d]    = 3'd0;
    a_s[d]     = 32'h0000_1234;
    b_s[d]     = 32'h0000_0005;
    hiwe_s[d]  = 1'b1;
    lowe_s[d]  = 1'b1;
    tick();
    start_s[d] = 1'b0;
    hiwe_s[d]  = 1'b0;
    lowe_s[d]  = 1'b0;
    for (int i = 2; i < k; i++) tick();
    cancel_s[d] = 1'b1;
    tick();
    cancel_s[d] = 1'b0;
    e.hi = mhi[d];
    e.lo = mlo[d];
    e.len = k;
    push(d, e);
    check("cancel_busy_low", {63'd0, busy_s[d]}, 64'd0);
    tick();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_s[d]) begin
        mcnt[d]++;
      end else if (mcnt[d] > 0) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (mon_e.len > 0) check("busy_width", 64'(mcnt[d]), 64'(mon_e.len));
          check("hilo_result", {hi_s[d], lo_s[d]}, {mon_e.hi, mon_e.lo});
        end
        mcnt[d] = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t     er;
    int       sel;
    int       d;
    logic [2:0] rop;
    total = 0;
    bad = 0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    reset_n = 1'b0;
    start_s = '0;
    op_s = '0;
    a_s = '0;
    b_s = '0;
    hiwe_s = '0;
    lowe_s = '0;
    cancel_s = '0;
    for (int i = 0; i < 2; i++) begin
      mhi[i] = '0;
      mlo[i] = '0;
    end
    tick();
    tick();
    check("reset_busy", {62'd0, busy_s}, 64'd0);
    check("reset_hilo0", {hi_s[0], lo_s[0]}, 64'd0);
    check("reset_hilo1", {hi_s[1], lo_s[1]}, 64'd0);
    reset_n = 1'b1;
    tick();

    do_op(0, 3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    check("mult_neg", {hi_s[0], lo_s[0]}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(0, 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    check("div_signed", {hi_s[0], lo_s[0]}, 64'h0000_0001_FFFF_FFFD);
    do_op(0, 3'd2, 32'h0000_0007, 32'h0000_0000, 1'b0);
    check("divu_by_zero", {hi_s[0], lo_s[0]}, 64'h0000_0007_FFFF_FFFF);

    do_mt(0, 1'b1, 1'b0, 32'h0000_0000);
    do_mt(0, 1'b0, 1'b1, 32'h0000_000A);
    do_op(0, 3'd4, 32'h0000_0003, 32'h0000_0004, 1'b0);
    check("msub", {hi_s[0], lo_s[0]}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(0, 3'd7, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("maddu", {hi_s[0], lo_s[0]}, 64'h0000_0001_FFFF_FFFC);

    do_cancel(0, 3'd1, 32'h0000_0002, 32'h0000_0003, 2);
    check("cancel_keeps_hilo", {hi_s[0], lo_s[0]}, 64'h0000_0001_FFFF_FFFC);
    do_cancel(0, 3'd3, 32'h0000_0064, 32'h0000_0007, 10);

    start_s[0] = 1'b1;
    cancel_s[0] = 1'b1;
    hiwe_s[0] = 1'b1;
    a_s[0] = 32'hDEAD_BEEF;
    op_s[0] = 3'd0;
    tick();
    start_s[0] = 1'b0;
    cancel_s[0] = 1'b0;
    hiwe_s[0] = 1'b0;
    check("start_cancel_same_cycle", {63'd0, busy_s[0]}, 64'd0);
    check("start_cancel_drops_mt", {hi_s[0], lo_s[0]}, {mhi[0], mlo[0]});

    do_op(0, 3'd6, 32'h0000_0003, 32'h0000_0003, 1'b1);
    do_op(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_neg1", {hi_s[0], lo_s[0]}, 64'h0000_0000_8000_0000);

    start_s[0] = 1'b1;
    op_s[0] = 3'd3;
    a_s[0] = 32'h0000_0009;
    b_s[0] = 32'h0000_0002;
    tick();
    start_s[0] = 1'b0;
    tick();
    tick();
    er.hi = '0;
    er.lo = '0;
    er.len = 0;
    q0.push_back(er);
    reset_n = 1'b0;
    #1;
    check("midop_reset_busy", {63'd0, busy_s[0]}, 64'd0);
    check("midop_reset_hilo", {hi_s[0], lo_s[0]}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      mhi[i] = '0;
      mlo[i] = '0;
    end
    tick();
    reset_n = 1'b1;
    tick();

    do_op(1, 3'd1, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
    do_op(1, 3'd2, 32'h0000_0064, 32'h0000_0007, 1'b0);
    do_mt(1, 1'b1, 1'b1, 32'h0000_0000);
    do_op(1, 3'd6, 32'h0000_0002, 32'h0000_0003, 1'b0);
    do_op(1, 3'd6, 32'h0000_0004, 32'h0000_0005, 1'b0);
    check("b2b_madd", {hi_s[1], lo_s[1]}, 64'h0000_0000_0000_001A);

    for (int it = 0; it < 60; it++) begin
      d = it % 2;
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        do_mt(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_val());
      end else begin
        rop = 3'($urandom_range(0, 7));
        do_op(d, rop, rnd_val(), rnd_val(), sel == 9);
      end
    end

    tick();
    tick();
    check("scoreboard_drained0", 64'(q0.size()), 64'd0);
    check("scoreboard_drained1", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
